// File: rtl/ddr4_dm_lane_delay_ctrl.sv
// Tap controller for the DDR4 DM lane I/O delay element: turns LOAD/INC/DEC/SET commands
// into single-tap MOVE pulses with direction setup, inter-move gap and limit/range aborts.
module ddr4_dm_lane_delay_ctrl #(
  parameter int unsigned TAP_W    = 8,
  parameter int unsigned LOAD_TAP = 1,
  parameter int unsigned MAX_TAP  = 255,
  parameter int unsigned MOVE_GAP = 4
) (
  input  logic             FAB_CLK,
  input  logic             RESET_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [TAP_W-1:0] CMD_TAPS,
  output logic             DONE,
  output logic             ERR,
  output logic [TAP_W-1:0] TAP_COUNT,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  input  logic             DELAY_LINE_OUT_OF_RANGE
);

  localparam int unsigned GapW = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
  localparam logic [GapW-1:0]  GapInit   = GapW'(MOVE_GAP - 1);
  localparam logic [TAP_W-1:0] LoadTap   = TAP_W'(LOAD_TAP);
  localparam logic [TAP_W-1:0] MaxTap    = TAP_W'(MAX_TAP);
  localparam logic [TAP_W:0]   MaxTapExt = (TAP_W + 1)'(MAX_TAP);

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpInc  = 2'b01;
  localparam logic [1:0] OpDec  = 2'b10;
  localparam logic [1:0] OpSet  = 2'b11;

  typedef enum logic [2:0] {StIdle, StLoad, StSetup, StPulse, StGap, StDone} state_e;

  state_e             state_q;
  logic               ready_q, done_q, err_q, load_q, move_q, dir_q;
  logic [TAP_W-1:0]   tap_q;
  logic [TAP_W:0]     rem_q;
  logic [GapW-1:0]    gap_q;

  logic [TAP_W:0]     tgt, cur, acc_rem;
  logic               acc_dir, acc_bad, at_limit;
  logic [TAP_W-1:0]   tap_step, tap_back;

  // Work implied by the command on the request bus, against the current tap.
  always_comb begin
    tgt     = {1'b0, CMD_TAPS};
    cur     = {1'b0, tap_q};
    acc_rem = '0;
    acc_dir = 1'b0;
    acc_bad = 1'b0;
    case (CMD_OP)
      OpInc: begin
        acc_rem = tgt;
        acc_dir = 1'b1;
      end
      OpDec: acc_rem = tgt;
      OpSet: begin
        if (tgt > MaxTapExt) begin
          acc_bad = 1'b1;
        end else if (tgt > cur) begin
          acc_rem = tgt - cur;
          acc_dir = 1'b1;
        end else begin
          acc_rem = cur - tgt;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    at_limit = dir_q ? (tap_q == MaxTap) : (tap_q == '0);
    tap_step = dir_q ? tap_q + TAP_W'(1) : tap_q - TAP_W'(1);
    tap_back = dir_q ? tap_q - TAP_W'(1) : tap_q + TAP_W'(1);
  end

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      move_q  <= 1'b0;
      dir_q   <= 1'b0;
      tap_q   <= LoadTap;
      rem_q   <= '0;
      gap_q   <= '0;
    end else begin
      done_q <= 1'b0;
      load_q <= 1'b0;
      move_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (CMD_VALID && ready_q) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            if (CMD_OP == OpLoad) begin
              load_q  <= 1'b1;
              state_q <= StLoad;
            end else if (acc_bad || acc_rem == '0) begin
              err_q   <= acc_bad;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              rem_q   <= acc_rem;
              dir_q   <= acc_dir;
              state_q <= StSetup;
            end
          end
        end
        StLoad: begin
          tap_q   <= LoadTap;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StSetup: begin
          if (at_limit) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            move_q  <= 1'b1;
            tap_q   <= tap_step;
            rem_q   <= rem_q - (TAP_W + 1)'(1);
            state_q <= StPulse;
          end
        end
        StPulse: begin
          gap_q   <= GapInit;
          state_q <= StGap;
        end
        StGap: begin
          if (DELAY_LINE_OUT_OF_RANGE) begin
            // The last move was rejected by the IOD: undo it and stop.
            tap_q   <= tap_back;
            err_q   <= 1'b1;
            rem_q   <= '0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (gap_q != '0) begin
            gap_q <= gap_q - GapW'(1);
          end else if (rem_q == '0) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (at_limit) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            move_q  <= 1'b1;
            tap_q   <= tap_step;
            rem_q   <= rem_q - (TAP_W + 1)'(1);
            state_q <= StPulse;
          end
        end
        StDone: begin
          ready_q <= 1'b1;
          dir_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          ready_q <= 1'b1;
          dir_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign CMD_READY            = ready_q;
  assign DONE                 = done_q;
  assign ERR                  = err_q;
  assign TAP_COUNT            = tap_q;
  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dir_q;

endmodule

// File: tb/tb_ddr4_dm_lane_delay_ctrl.sv
// Bench for ddr4_dm_lane_delay_ctrl: directed and random commands checked against a
// transaction-level model of pulse count, final tap, error flag and completion latency.
module tb_ddr4_dm_lane_delay_ctrl;

  localparam int TapW    = 8;
  localparam int LoadTap = 1;
  localparam int MaxTap  = 255;
  localparam int Gap     = 4;
  localparam int Budget  = 3000;

  logic            clk_i = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic [1:0]      cmd_op = 2'b00;
  logic [TapW-1:0] cmd_taps = '0;
  logic            oor = 1'b0;
  logic            cmd_ready, done, err, dl_load, dl_move, dl_dir;
  logic [TapW-1:0] tap_count;

  int n_vec = 0;
  int n_err = 0;
  int m_tap = LoadTap;

  ddr4_dm_lane_delay_ctrl #(
    .TAP_W   (TapW),
    .LOAD_TAP(LoadTap),
    .MAX_TAP (MaxTap),
    .MOVE_GAP(Gap)
  ) u_dut (
    .FAB_CLK                (clk_i),
    .RESET_N                (rst_n),
    .CMD_VALID              (cmd_valid),
    .CMD_READY              (cmd_ready),
    .CMD_OP                 (cmd_op),
    .CMD_TAPS               (cmd_taps),
    .DONE                   (done),
    .ERR                    (err),
    .TAP_COUNT              (tap_count),
    .DELAY_LINE_LOAD        (dl_load),
    .DELAY_LINE_MOVE        (dl_move),
    .DELAY_LINE_DIRECTION   (dl_dir),
    .DELAY_LINE_OUT_OF_RANGE(oor)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Command-level model. ok/oj: out-of-range raised in gap cycle oj after pulse ok (0 = never).
  // lat is the cycle (counted from the accept edge) in which DONE is high.
  task automatic model(input int op, input int taps, input int ok, input int oj, inout int tap,
                       output int pulses, output int e_err, output int lat, output int dir,
                       output int loads, output int moving, output int bad);
    int n;
    pulses = 0; e_err = 0; dir = 0; loads = 0; moving = 0; bad = 0; n = 0;
    lat = 1;
    if (op == 0) begin
      tap = LoadTap; loads = 1; lat = 2;
      return;
    end
    if (op == 1) begin
      n = taps; dir = 1;
    end else if (op == 2) begin
      n = taps;
    end else if (taps > MaxTap) begin
      bad = 1;
    end else if (taps > tap) begin
      n = taps - tap; dir = 1;
    end else begin
      n = tap - taps;
    end
    if (bad) begin
      e_err = 1; dir = 0;
      return;
    end
    if (n == 0) begin
      dir = 0;
      return;
    end
    moving = 1;
    lat = -1;
    for (int i = 1; i <= n; i++) begin
      if ((dir == 1 && tap == MaxTap) || (dir == 0 && tap == 0)) begin
        e_err = 1;
        break;
      end
      pulses++;
      tap += (dir == 1) ? 1 : -1;
      if (ok == i) begin
        tap -= (dir == 1) ? 1 : -1;
        e_err = 1;
        lat = 3 + (i - 1) * (1 + Gap) + oj;
        break;
      end
    end
    if (lat < 0) lat = 2 + pulses * (1 + Gap);
  endtask

  task automatic run_cmd(input int op, input int taps, input int ok, input int oj,
                         input bit hold_valid);
    int e_p, e_err, e_lat, e_dir, e_loads, e_mov, e_bad;
    int mt, t, c, pulses, loads, lastp, overlap, dirbad, prevdir, got_done;
    mt = m_tap;
    model(op, taps, ok, oj, mt, e_p, e_err, e_lat, e_dir, e_loads, e_mov, e_bad);
    t = 0;
    while (!cmd_ready && t < Budget) begin
      @(negedge clk_i);
      t++;
    end
    if (!cmd_ready) check_eq("ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_taps  = TapW'(taps);
    @(posedge clk_i);
    #1;
    if (!hold_valid) cmd_valid = 1'b0;
    c = 0; pulses = 0; loads = 0; lastp = 0; overlap = 0; dirbad = 0; got_done = 0;
    prevdir = dl_dir;
    while (c < Budget && got_done == 0) begin
      @(negedge clk_i);
      c++;
      if (c == 1) begin
        check_eq("busy_ready", cmd_ready, 0);
        check_eq("err_at_accept", err, e_bad);
      end
      if (dl_move) begin
        pulses++;
        lastp = c;
        if (dl_dir !== e_dir[0] || prevdir !== e_dir) dirbad++;
      end
      if (dl_load) loads++;
      if (dl_load && dl_move) overlap++;
      if (done) got_done = 1;
      prevdir = dl_dir;
      oor = (ok != 0 && pulses == ok && c == lastp + oj);
    end
    oor = 1'b0;
    check_eq("done_latency", got_done ? c : -1, e_lat);
    check_eq("move_pulses", pulses, e_p);
    check_eq("load_pulses", loads, e_loads);
    check_eq("load_move_overlap", overlap, 0);
    check_eq("dir_setup_stable", dirbad, 0);
    check_eq("dir_at_done", prevdir, e_mov ? e_dir : 0);
    check_eq("tap_count", tap_count, mt);
    check_eq("err", err, e_err);
    @(negedge clk_i);
    check_eq("ready_after_done", cmd_ready, 1);
    check_eq("dir_idle", dl_dir, 0);
    check_eq("err_held", err, e_err);
    check_eq("done_single", done, 0);
    m_tap = mt;
  endtask

  task automatic reset_mid_command();
    int t, mv;
    t = 0;
    while (!cmd_ready && t < Budget) begin
      @(negedge clk_i);
      t++;
    end
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_taps = TapW'(10);
    @(posedge clk_i);
    #1;
    cmd_valid = 1'b0;
    mv = 0; t = 0;
    while (mv < 2 && t < Budget) begin
      @(negedge clk_i);
      t++;
      if (dl_move) mv++;
    end
    check_eq("rst_reach_2nd_pulse", mv, 2);
    @(negedge clk_i);
    rst_n = 1'b0;
    @(negedge clk_i);
    check_eq("rst_move", dl_move, 0);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_tap", tap_count, LoadTap);
    check_eq("rst_err", err, 0);
    check_eq("rst_done", done, 0);
    rst_n = 1'b1;
    mv = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (dl_move || dl_load || done) mv++;
    end
    check_eq("rst_quiet", mv, 0);
    m_tap = LoadTap;
  endtask

  initial begin
    int op, taps, ok, oj;
    repeat (3) @(negedge clk_i);
    check_eq("reset_ready", cmd_ready, 1);
    check_eq("reset_done", done, 0);
    check_eq("reset_err", err, 0);
    check_eq("reset_tap", tap_count, LoadTap);
    check_eq("reset_dl", {dl_load, dl_move, dl_dir}, 0);
    rst_n = 1'b1;
    @(negedge clk_i);

    run_cmd(0, 0, 0, 0, 0);      // LOAD
    run_cmd(1, 3, 0, 0, 0);      // INC 3, DONE at 17
    run_cmd(3, 0, 0, 0, 0);      // SET 0 from 4
    run_cmd(2, 1, 0, 0, 0);      // DEC at tap 0 -> limit error
    run_cmd(3, 10, 0, 0, 0);
    run_cmd(1, 5, 2, 1, 0);      // out-of-range after 2nd pulse
    run_cmd(1, 1, 0, 0, 0);      // error clears on accept
    run_cmd(3, 8'h80, 0, 0, 0);
    run_cmd(3, 8'h80, 0, 0, 0);  // zero work
    run_cmd(1, 0, 0, 0, 0);
    run_cmd(1, 2, 0, 0, 1);      // valid held through busy period
    run_cmd(1, 0, 0, 0, 0);
    run_cmd(3, 253, 0, 0, 0);
    run_cmd(1, 5, 0, 0, 0);      // hits MAX_TAP
    run_cmd(3, 255, 0, 0, 0);
    run_cmd(2, 3, 3, Gap, 0);    // out-of-range in last gap cycle

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      if (op == 3) begin
        if ($urandom_range(0, 3) == 0) taps = ($urandom_range(0, 1) == 1) ? MaxTap : 0;
        else begin
          taps = m_tap + $urandom_range(0, 16) - 8;
          if (taps < 0) taps = 0;
          if (taps > MaxTap) taps = MaxTap;
        end
      end else begin
        taps = $urandom_range(0, 6);
      end
      ok = 0; oj = 0;
      if ($urandom_range(0, 3) == 0) begin
        ok = $urandom_range(1, 3);
        oj = $urandom_range(1, Gap);
      end
      run_cmd(op, taps, ok, oj, 0);
    end

    reset_mid_command();
    run_cmd(1, 2, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
